// File: rtl/speech_lpf_mc.sv
// speech_lpf_mc: multichannel first-order IIR low-pass for speech paths.
// Each sample period every channel is computed as
// y = sat((b1*x + b2*x1 - a2*y1) >>> FRAC), using a single multiplier
// that is time-shared across all channels.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a divider tick; a tick captures inputs and coeffs
// MAC   | 3 multiply-accumulate steps per channel, channel 0 first
// WRITE | commit x1/y1 filter state and drive out; out_stb follows
`timescale 1ns/1ps

module speech_lpf_mc #(
    parameter int DW   = 16,
    parameter int CH   = 2,
    parameter int CW   = 18,
    parameter int FRAC = 15,
    parameter int DIVW = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DIVW-1:0]    div,
    input  logic [CW-1:0]      a2,
    input  logic [CW-1:0]      b1,
    input  logic [CW-1:0]      b2,
    input  logic               bypass,
    input  logic [CH*DW-1:0]   in,
    output logic [CH*DW-1:0]   out,
    output logic               out_stb,
    output logic               overrun
);

    localparam int AW  = DW + CW + 2;
    localparam int PW  = DW + CW;
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

    localparam logic signed [AW-1:0] YMAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] YMIN = ~YMAX;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DIVW-1:0] cnt;
    logic [DIVW-1:0] div_m1;
    logic            tick;

    logic [CHW-1:0]  ch_idx;
    logic [1:0]      phase;
    logic            last_mac;
    logic            capture;
    logic            lost;

    logic signed [DW-1:0] x_cap [CH];
    logic signed [DW-1:0] x1    [CH];
    logic signed [DW-1:0] y1    [CH];
    logic signed [DW-1:0] y_new [CH];
    logic signed [CW-1:0] a2_c, b1_c, b2_c;
    logic                 byp_c;

    logic signed [CW-1:0] coef;
    logic signed [DW-1:0] samp;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] prod_x;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_sum;
    logic signed [AW-1:0] y_shift;
    logic signed [DW-1:0] y_sat;

    // div = 0 behaves as div = 1, i.e. a tick every cycle
    assign div_m1   = (div == '0) ? '0 : div - 1'b1;
    assign tick     = (cnt == div_m1);
    assign last_mac = (phase == 2'd2) && (ch_idx == CHW'(CH - 1));

    // Sample-period divider; also snaps back to 0 if div shrinks below cnt
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (cnt >= div_m1)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM next state; ticks outside IDLE are dropped and flagged
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        lost      = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    capture   = 1'b1;
                    state_nxt = MAC;
                end
            end
            MAC: begin
                lost = tick;
                if (last_mac)
                    state_nxt = WRITE;
            end
            WRITE: begin
                lost      = tick;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Channel / MAC-phase sequencing
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch_idx <= '0;
            phase  <= '0;
        end else if (state != MAC) begin
            ch_idx <= '0;
            phase  <= '0;
        end else if (phase == 2'd2) begin
            phase  <= '0;
            ch_idx <= ch_idx + 1'b1;
        end else begin
            phase  <= phase + 1'b1;
        end
    end

    // Shared multiplier operand select and accumulate / saturate path
    always_comb begin
        coef = b1_c;
        samp = x_cap[ch_idx];
        case (phase)
            2'd1: begin
                coef = b2_c;
                samp = x1[ch_idx];
            end
            2'd2: begin
                coef = a2_c;
                samp = y1[ch_idx];
            end
            default: ;
        endcase
        prod   = coef * samp;
        prod_x = {{(AW-PW){prod[PW-1]}}, prod};
        case (phase)
            2'd0:    acc_sum = prod_x;
            2'd1:    acc_sum = acc + prod_x;
            default: acc_sum = acc - prod_x;
        endcase
        y_shift = acc_sum >>> FRAC;
        if (y_shift > YMAX)
            y_sat = YMAX[DW-1:0];
        else if (y_shift < YMIN)
            y_sat = YMIN[DW-1:0];
        else
            y_sat = y_shift[DW-1:0];
    end

    // Input capture, accumulation, state commit and output drive
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < CH; k++) begin
                x_cap[k] <= '0;
                x1[k]    <= '0;
                y1[k]    <= '0;
                y_new[k] <= '0;
            end
            a2_c    <= '0;
            b1_c    <= '0;
            b2_c    <= '0;
            byp_c   <= 1'b0;
            acc     <= '0;
            out     <= '0;
            out_stb <= 1'b0;
            overrun <= 1'b0;
        end else begin
            out_stb <= (state == WRITE);
            if (lost)
                overrun <= 1'b1;
            if (capture) begin
                for (int k = 0; k < CH; k++)
                    x_cap[k] <= in[k*DW +: DW];
                a2_c  <= a2;
                b1_c  <= b1;
                b2_c  <= b2;
                byp_c <= bypass;
            end
            if (state == MAC) begin
                acc <= acc_sum;
                if (phase == 2'd2)
                    y_new[ch_idx] <= y_sat;
            end
            if (state == WRITE) begin
                for (int k = 0; k < CH; k++) begin
                    x1[k] <= x_cap[k];
                    y1[k] <= y_new[k];
                    out[k*DW +: DW] <= byp_c ? x_cap[k] : y_new[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_speech_lpf_mc.sv
// Directed bench for speech_lpf_mc (CH=2, DW=16): step response, saturation,
// overrun, bypass, mid-sequence reset and divider retargeting.
`timescale 1ns/1ps

module tb_speech_lpf_mc;

    localparam int DW = 16;
    localparam int CH = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [9:0]        div;
    logic [17:0]       a2, b1, b2;
    logic              bypass;
    logic [CH*DW-1:0]  in;
    logic [CH*DW-1:0]  out;
    logic              out_stb;
    logic              overrun;

    int n_assert = 0;
    int n_fail   = 0;
    int n        = 0;
    int at       = 0;
    logic stb_seen;

    speech_lpf_mc #(.DW(16), .CH(2), .CW(18), .FRAC(15), .DIVW(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .div     (div),
        .a2      (a2),
        .b1      (b1),
        .b2      (b2),
        .bypass  (bypass),
        .in      (in),
        .out     (out),
        .out_stb (out_stb),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint chv(input int k);
        logic signed [DW-1:0] v;
        v = out[k*DW +: DW];
        return longint'(v);
    endfunction

    // one clock: sample point is 1 ns after the rising edge; n = cycle index
    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        n = 1;
    endtask

    task automatic wait_stb(input int budget, output int got);
        got = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (out_stb === 1'b1) begin
                got = n;
                break;
            end
        end
    endtask

    task automatic default_coefs();
        a2 = 18'(-32064);
        b1 = 18'(352);
        b2 = 18'(352);
    endtask

    initial begin
        reset  = 1'b0;
        div    = 10'd256;
        bypass = 1'b0;
        in     = '0;
        default_coefs();

        // reset state
        repeat (2) step();
        chk("rst_out", longint'(out), 0);
        chk("rst_stb", longint'(out_stb), 0);
        chk("rst_overrun", longint'(overrun), 0);

        // step response, div = 256
        in = {16'(0), 16'(10000)};
        do_reset();
        wait_stb(1000, at);
        chk("step_first_stb_cycle", at, 264);
        chk("step_y0_ch0", chv(0), 107);
        chk("step_y0_ch1", chv(1), 0);
        step();
        chk("step_stb_one_cycle", longint'(out_stb), 0);
        repeat (100) step();
        chk("step_hold_ch0", chv(0), 107);
        wait_stb(1000, at);
        chk("step_second_stb_cycle", at, 520);
        chk("step_y1_ch0", chv(0), 319);
        chk("step_y1_ch1", chv(1), 0);

        // saturation, div = 16
        div = 10'd16;
        a2  = 18'(0);
        b1  = 18'(32767);
        b2  = 18'(32767);
        in  = {16'(-32768), 16'(32767)};
        do_reset();
        wait_stb(200, at);
        chk("sat_s0_ch0", chv(0), 32766);
        chk("sat_s0_ch1", chv(1), -32767);
        wait_stb(200, at);
        chk("sat_s1_ch0", chv(0), 32767);
        chk("sat_s1_ch1", chv(1), -32768);
        in = {16'(-32768), 16'(-32768)};
        wait_stb(200, at);
        chk("sat_s2_ch0", chv(0), -1);
        wait_stb(200, at);
        chk("sat_s3_ch0", chv(0), -32768);
        chk("sat_s3_ch1", chv(1), -32768);

        // overrun, div = 4
        default_coefs();
        div = 10'd4;
        in  = {16'(-10000), 16'(10000)};
        do_reset();
        while (n < 8) step();
        chk("ovr_before_second_tick", longint'(overrun), 0);
        step();
        chk("ovr_after_second_tick", longint'(overrun), 1);
        wait_stb(100, at);
        chk("ovr_stb0_cycle", at, 12);
        chk("ovr_s0_ch0", chv(0), 107);
        chk("ovr_s0_ch1", chv(1), -108);
        wait_stb(100, at);
        chk("ovr_stb1_cycle", at, 20);
        chk("ovr_s1_ch0", chv(0), 319);
        chk("ovr_s1_ch1", chv(1), -321);
        wait_stb(100, at);
        chk("ovr_stb2_cycle", at, 28);
        chk("ovr_sticky", longint'(overrun), 1);

        // bypass then resume filtering, div = 16
        div    = 10'd16;
        bypass = 1'b1;
        in     = {16'(0), 16'(1234)};
        do_reset();
        wait_stb(200, at);
        chk("byp_stb_cycle", at, 24);
        chk("byp_ch0", chv(0), 1234);
        bypass = 1'b0;
        wait_stb(200, at);
        chk("byp_resume_ch0", chv(0), 39);

        // reset 2 cycles after a tick, div = 10
        div = 10'd10;
        in  = {16'(0), 16'(10000)};
        do_reset();
        wait_stb(200, at);
        chk("mrst_pre_ch0", chv(0), 107);
        while (n < 22) step();
        reset = 1'b0;
        #1;
        chk("mrst_out_zero", longint'(out), 0);
        chk("mrst_stb_low", longint'(out_stb), 0);
        stb_seen = 1'b0;
        repeat (12) begin
            step();
            if (out_stb !== 1'b0) stb_seen = 1'b1;
        end
        chk("mrst_no_stb_in_reset", longint'(stb_seen), 0);
        reset = 1'b1;
        n = 1;
        wait_stb(200, at);
        chk("mrst_first_stb_cycle", at, 18);
        chk("mrst_restart_ch0", chv(0), 107);

        // div lowered from 256 to 10 while count = 100
        div = 10'd256;
        do_reset();
        while (n < 101) step();
        div = 10'd10;
        wait_stb(200, at);
        chk("divchg_stb0_cycle", at, 119);
        wait_stb(200, at);
        chk("divchg_stb1_cycle", at, 129);
        wait_stb(200, at);
        chk("divchg_stb2_cycle", at, 139);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/speech_lpf_mc.md
SPEECH_LPF_MC -- requirements
Module: speech_lpf_mc

Interface
REQ-001 SHALL have parameter DW, default 16: sample width, signed two's complement.
REQ-002 SHALL have parameter CH, default 2: channel count, at least 1.
REQ-003 SHALL have parameter CW, default 18: coefficient width, signed.
REQ-004 SHALL have parameter FRAC, default 15: coefficient fractional bits.
REQ-005 SHALL have parameter DIVW, default 10: divider width.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port div, input, DIVW bits: clk cycles per sample period.
REQ-009 SHALL have ports a2, b1, b2, input, CW bits each: filter coefficients, signed.
REQ-010 SHALL have port bypass, input, 1 bit: pass input through unfiltered.
REQ-011 SHALL have port in, input, CH*DW bits: channel k occupies bits [k*DW +: DW].
REQ-012 SHALL have port out, output, CH*DW bits: filtered samples, same packing as in.
REQ-013 SHALL have port out_stb, output, 1 bit: one-cycle pulse when out updates.
REQ-014 SHALL have port overrun, output, 1 bit: sticky flag, set when a tick is lost.

Function
REQ-015 SHALL count 0..div-1 in a divider and assert an internal tick on the cycle count==div-1, then wrap to 0.
REQ-016 SHALL treat div=0 as div=1; SHALL wrap the counter to 0 immediately if count exceeds div-1 after div changes.
REQ-017 SHALL, on a tick in IDLE, capture all channels of in, a2, b1, b2 and bypass into holding registers; later input changes have no effect until the next tick.
REQ-018 SHALL run FSM states IDLE -> MAC (3 cycles per channel, channels 0..CH-1 in order) -> WRITE -> IDLE, using one shared CW x DW multiplier.
REQ-019 SHALL compute per channel acc = b1*x + b2*x1 - a2*y1, with acc at least DW+CW+2 bits wide and no intermediate overflow.
REQ-020 SHALL form y by arithmetic right-shift of acc by FRAC (floor), then saturate to [-2^(DW-1), 2^(DW-1)-1].
REQ-021 SHALL, in WRITE, update x1 to the captured x and y1 to the saturated y for every channel.
REQ-022 SHALL, in WRITE, drive out with y when captured bypass=0, or with captured x when bypass=1; filter state keeps updating in bypass.
REQ-023 SHALL pulse out_stb high for exactly the cycle after WRITE, the cycle out first shows new values; total latency from tick is 3*CH+2 cycles.
REQ-024 SHALL ignore a tick arriving when the FSM is not in IDLE and set overrun; overrun clears only by reset.
REQ-025 SHALL hold out constant between out_stb pulses.
REQ-026 SHALL, with a2 = -32064, b1 = b2 = 352 and FRAC = 15, realise the single-pole RC speech low-pass at a 192 kHz sample rate (clk 49.152 MHz, div = 256).

Reset
REQ-027 SHALL, while reset = 0, force out = 0, out_stb = 0, overrun = 0, divider = 0, FSM = IDLE, and all x1/y1 = 0, regardless of clk.
REQ-028 SHALL abandon any MAC sequence in progress on reset assertion; no partial WRITE occurs.
REQ-029 SHALL produce the first tick div cycles after reset deasserts.

Verification
REQ-030 SHALL be checked with a step test: CH=2, default coefficients, div=256, in ch0 = 10000, ch1 = 0 -> ch0 out = 107 then 319 on successive out_stb pulses, ch1 stays 0.
REQ-031 SHALL be checked for saturation: a2 = 0, b1 = b2 = 32767, in = 32767 held -> out = 32767 from the second sample; in = -32768 -> out = -32768.
REQ-032 SHALL be checked for overrun: CH=2, div=4 -> overrun = 1 after the second tick; out_stb pulses every 8 cycles; no corrupted outputs.
REQ-033 SHALL be checked for bypass: bypass = 1, in ch0 = 1234 -> out = 1234 at out_stb; clearing bypass next tick -> out continues the filter trajectory with no reset of state.
REQ-034 SHALL be checked for mid-sequence reset: reset asserted 2 cycles after a tick -> out = 0 and no out_stb; after release, the first out_stb comes div + 3*CH + 2 cycles later.
REQ-035 SHALL be checked for a div change mid-period: div lowered from 256 to 10 while count = 100 -> counter wraps next cycle, then ticks every 10 cycles.
